// File: rtl/decode_pkg.sv
// Shared decode constants and the ID/EX pipeline record for decode_regfile.
// The record is sized for the widest supported datapath; narrower builds zero-fill it.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_LO  = 21;
  localparam int RT_LO  = 16;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [MAX_DATA_W-1:0] pc;
    logic [MAX_DATA_W-1:0] rd1;
    logic [MAX_DATA_W-1:0] rd2;
    logic [MAX_DATA_W-1:0] imm;
    logic [MAX_ADDR_W-1:0] rs;
    logic [MAX_ADDR_W-1:0] rt;
    logic [MAX_ADDR_W-1:0] dst;
    logic                  rtype;
  } idex_t;

  // Logical-immediate opcodes take a zero-extended immediate; all others sign-extend.
  function automatic logic imm_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/decode_regfile_regfile_core.sv
// Register file with hardwired zero register, one write port and two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching reads.
module regfile_core #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2
);

  logic [DATA_W-1:0] mem_reg [NUM_REGS];
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              wr_live;

  assign wr_live    = wr_en && (wr_addr != '0);
  assign rd_addr[0] = rd_addr1;
  assign rd_addr[1] = rd_addr2;
  assign rd_data1   = rd_data[0];
  assign rd_data2   = rd_data[1];

  // Reset has priority, so a write-back sampled together with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_live) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
      assign rd_data[gi] = (rd_addr[gi] == '0)                  ? '0 :
                           (wr_live && wr_addr == rd_addr[gi]) ? wr_data :
                                                                 mem_reg[rd_addr[gi]];
`else
      assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 : mem_reg[rd_addr[gi]];
`endif
    end
  endgenerate

endmodule

// File: rtl/decode_regfile.sv
// Instruction-decode stage: field decode, immediate extension, register read and ID/EX register.
// Same-cycle write-back forwarding is enabled by defining REGFILE_BYPASS_EN.
module decode_regfile
  import decode_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              id_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              idex_valid,
  output logic [DATA_W-1:0] idex_pc,
  output logic [DATA_W-1:0] idex_rd1,
  output logic [DATA_W-1:0] idex_rd2,
  output logic [DATA_W-1:0] idex_imm,
  output logic [ADDR_W-1:0] idex_rs,
  output logic [ADDR_W-1:0] idex_rt,
  output logic [ADDR_W-1:0] idex_dst,
  output logic              idex_rtype
);

  logic [5:0]        op;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  idex_t             idex_reg;
  idex_t             idex_next;
  logic              unused_bits;

  assign op    = instruction[OP_HI:OP_LO];
  assign rs    = instruction[RS_LO +: ADDR_W];
  assign rt    = instruction[RT_LO +: ADDR_W];
  assign rd    = instruction[RD_LO +: ADDR_W];
  assign imm16 = instruction[IMM_HI:IMM_LO];

  assign imm_ext = imm_zero_ext(op) ? DATA_W'(imm16) : DATA_W'($signed(imm16));

  regfile_core #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wb_en),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data),
    .rd_addr1 (rs),
    .rd_data1 (rd1),
    .rd_addr2 (rt),
    .rd_data2 (rd2)
  );

  always_comb begin
    idex_next = idex_reg;
    if (flush) begin
      idex_next = '0;
    end else if (!stall) begin
      idex_next.valid = id_valid;
      idex_next.pc    = MAX_DATA_W'(pc_in);
      idex_next.rd1   = MAX_DATA_W'(rd1);
      idex_next.rd2   = MAX_DATA_W'(rd2);
      idex_next.imm   = MAX_DATA_W'(imm_ext);
      idex_next.rs    = MAX_ADDR_W'(rs);
      idex_next.rt    = MAX_ADDR_W'(rt);
      idex_next.dst   = MAX_ADDR_W'((op == OP_RTYPE) ? rd : rt);
      idex_next.rtype = (op == OP_RTYPE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_reg <= '0;
    end else begin
      idex_reg <= idex_next;
    end
  end

  assign idex_valid = idex_reg.valid;
  assign idex_pc    = idex_reg.pc[DATA_W-1:0];
  assign idex_rd1   = idex_reg.rd1[DATA_W-1:0];
  assign idex_rd2   = idex_reg.rd2[DATA_W-1:0];
  assign idex_imm   = idex_reg.imm[DATA_W-1:0];
  assign idex_rs    = idex_reg.rs[ADDR_W-1:0];
  assign idex_rt    = idex_reg.rt[ADDR_W-1:0];
  assign idex_dst   = idex_reg.dst[ADDR_W-1:0];
  assign idex_rtype = idex_reg.rtype;

  // Zero-filled record bits above DATA_W/ADDR_W and truncated index bits are intentionally dropped.
  assign unused_bits = ^{idex_reg, instruction};

endmodule

// File: tb/tb_decode_regfile.sv
// Randomized bench for decode_regfile: a 32x32 instance checked against an array-based
// reference model every cycle, plus a 16-bit/8-register instance for the parameter sweep.
module tb_decode_regfile;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int BDW = 16;
  localparam int BNR = 8;
  localparam int BAW = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, id_valid, stall, flush, wb_en;
  logic [31:0]   instruction;
  logic [DW-1:0] pc_in, wb_data;
  logic [AW-1:0] wb_addr;
  logic          idex_valid, idex_rtype;
  logic [DW-1:0] idex_pc, idex_rd1, idex_rd2, idex_imm;
  logic [AW-1:0] idex_rs, idex_rt, idex_dst;

  logic           b_id_valid, b_wb_en;
  logic [31:0]    b_instruction;
  logic [BDW-1:0] b_pc_in, b_wb_data;
  logic [BAW-1:0] b_wb_addr;
  logic           b_idex_valid, b_idex_rtype;
  logic [BDW-1:0] b_idex_pc, b_idex_rd1, b_idex_rd2, b_idex_imm;
  logic [BAW-1:0] b_idex_rs, b_idex_rt, b_idex_dst;

  decode_regfile #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .pc_in(pc_in),
    .id_valid(id_valid), .stall(stall), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .idex_valid(idex_valid),
    .idex_pc(idex_pc), .idex_rd1(idex_rd1), .idex_rd2(idex_rd2),
    .idex_imm(idex_imm), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_dst(idex_dst), .idex_rtype(idex_rtype)
  );

  decode_regfile #(.DATA_W(BDW), .NUM_REGS(BNR)) dut_small (
    .clk(clk), .rst_n(rst_n), .instruction(b_instruction), .pc_in(b_pc_in),
    .id_valid(b_id_valid), .stall(1'b0), .flush(1'b0), .wb_en(b_wb_en),
    .wb_addr(b_wb_addr), .wb_data(b_wb_data), .idex_valid(b_idex_valid),
    .idex_pc(b_idex_pc), .idex_rd1(b_idex_rd1), .idex_rd2(b_idex_rd2),
    .idex_imm(b_idex_imm), .idex_rs(b_idex_rs), .idex_rt(b_idex_rt),
    .idex_dst(b_idex_dst), .idex_rtype(b_idex_rtype)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural register array and the expected ID/EX contents.
  logic [31:0] m_rf [NR];
  logic        e_valid = 1'b0, e_rtype = 1'b0;
  logic [31:0] e_pc = '0, e_rd1 = '0, e_rd2 = '0, e_imm = '0;
  int          e_rs = 0, e_rt = 0, e_dst = 0;

  function automatic logic [31:0] model_read(input int idx);
    if (idx == 0) return 32'h0;
    if (BYP && wb_en && int'(wb_addr) != 0 && int'(wb_addr) == idx) return wb_data;
    return m_rf[idx];
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] ins);
    int op;
    int s;
    op = int'(ins[31:26]);
    s  = int'(ins[15:0]);
    if (op == 12 || op == 13 || op == 14) return 32'(s);
    if (s >= 32768) s = s - 65536;
    return 32'(s);
  endfunction

  task automatic step(input string tag);
    logic        nv, nrt;
    logic [31:0] npc, nrd1, nrd2, nimm;
    int          nrs, nrtx, ndst, op;
    nv = e_valid; nrt = e_rtype; npc = e_pc; nrd1 = e_rd1; nrd2 = e_rd2; nimm = e_imm;
    nrs = e_rs; nrtx = e_rt; ndst = e_dst;
    if (!rst_n || flush) begin
      nv = 0; nrt = 0; npc = 0; nrd1 = 0; nrd2 = 0; nimm = 0; nrs = 0; nrtx = 0; ndst = 0;
    end else if (!stall) begin
      op   = int'(instruction[31:26]);
      nrs  = int'(instruction[25:21]) % NR;
      nrtx = int'(instruction[20:16]) % NR;
      ndst = (op == 0) ? int'(instruction[15:11]) % NR : nrtx;
      nv   = id_valid;
      nrt  = (op == 0);
      npc  = pc_in;
      nrd1 = model_read(nrs);
      nrd2 = model_read(nrtx);
      nimm = model_imm(instruction);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_rf[i] = '0;
    end else if (wb_en && wb_addr != 0) begin
      m_rf[wb_addr] = wb_data;
    end
    e_valid = nv; e_rtype = nrt; e_pc = npc; e_rd1 = nrd1; e_rd2 = nrd2; e_imm = nimm;
    e_rs = nrs; e_rt = nrtx; e_dst = ndst;
    check({tag, ".valid"}, idex_valid, e_valid);
    check({tag, ".pc"},    idex_pc,    e_pc);
    check({tag, ".rd1"},   idex_rd1,   e_rd1);
    check({tag, ".rd2"},   idex_rd2,   e_rd2);
    check({tag, ".imm"},   idex_imm,   e_imm);
    check({tag, ".rs"},    idex_rs,    64'(e_rs));
    check({tag, ".rt"},    idex_rt,    64'(e_rt));
    check({tag, ".dst"},   idex_dst,   64'(e_dst));
    check({tag, ".rtype"}, idex_rtype, e_rtype);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_rf[i] = '0;
    rst_n = 0; id_valid = 0; stall = 0; flush = 0; wb_en = 0;
    instruction = '0; pc_in = '0; wb_addr = '0; wb_data = '0;
    b_id_valid = 0; b_wb_en = 0; b_instruction = '0; b_pc_in = '0; b_wb_addr = '0; b_wb_data = '0;

    step("rst0");
    step("rst1");
    check("rst.valid", idex_valid, 0);
    check("rst.imm", idex_imm, 0);
    check("rst.small_valid", b_idex_valid, 0);

    rst_n = 1; instruction = 32'h012A4020; id_valid = 1; pc_in = 32'h100;
    step("add");
    check("add.rs", idex_rs, 9);
    check("add.rt", idex_rt, 10);
    check("add.dst", idex_dst, 8);
    check("add.rtype", idex_rtype, 1);
    check("add.rd1", idex_rd1, 0);
    check("add.valid", idex_valid, 1);

    wb_en = 1; wb_addr = 9; wb_data = 32'h11110000;
    step("wb9");
    wb_en = 0;
    step("add2");
    check("add2.rd1", idex_rd1, 32'h11110000);

    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
    step("wb0");
    wb_en = 0; instruction = 32'h00004020;
    step("rd0");
    check("rd0.rd1", idex_rd1, 0);
    check("rd0.rd2", idex_rd2, 0);

    instruction = 32'h012A4020; wb_en = 1; wb_addr = 10; wb_data = 32'hDEADBEEF;
    step("byp");
    check("byp.rd2", idex_rd2, BYP ? 32'hDEADBEEF : 32'h0);
    wb_en = 0;

    instruction = 32'h21098001;
    step("addi");
    check("addi.imm", idex_imm, 32'hFFFF8001);
    check("addi.dst", idex_dst, 9);
    check("addi.rtype", idex_rtype, 0);
    instruction = 32'h35098001;
    step("ori");
    check("ori.imm", idex_imm, 32'h00008001);

    stall = 1; instruction = 32'h012A4020; pc_in = 32'h200;
    wb_en = 1; wb_addr = 5; wb_data = 32'h55;
    step("stall1");
    wb_en = 0; instruction = 32'h8C000000;
    step("stall2");
    check("stall.imm", idex_imm, 32'h00008001);
    flush = 1;
    step("flush");
    check("flush.valid", idex_valid, 0);
    check("flush.pc", idex_pc, 0);
    check("flush.imm", idex_imm, 0);
    check("flush.dst", idex_dst, 0);
    stall = 0; flush = 0; instruction = 32'h00A00000;
    step("rd5");
    check("rd5.rd1", idex_rd1, 32'h55);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0: op = 6'h00;
        1: op = 6'h0C;
        2: op = 6'h0D;
        3: op = 6'h0E;
        4: op = 6'h08;
        default: op = 6'($urandom);
      endcase
      rst_n       = ($urandom_range(0, 63) != 0);
      instruction = {op, 26'($urandom)};
      pc_in       = $urandom;
      id_valid    = 1'($urandom);
      stall       = ($urandom_range(0, 5) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      wb_en       = 1'($urandom);
      wb_data     = $urandom;
      case ($urandom_range(0, 2))
        0: wb_addr = instruction[25:21];
        1: wb_addr = instruction[20:16];
        default: wb_addr = 5'($urandom);
      endcase
      step("rnd");
    end

    rst_n = 1; stall = 0; flush = 0; wb_en = 0;
    b_wb_en = 1; b_wb_addr = 7; b_wb_data = 16'hABCD;
    b_instruction = 32'h03E00000; b_id_valid = 1; b_pc_in = 16'h0040;
    step("sw1");
    b_wb_en = 0;
    step("sw2");
    check("small.rd1", b_idex_rd1, 16'hABCD);
    check("small.rs", b_idex_rs, 7);
    check("small.valid", b_idex_valid, 1);
    check("small.pc", b_idex_pc, 16'h0040);
    b_instruction = 32'h21098001;
    step("sw3");
    check("small.imm", b_idex_imm, 16'h8001);
    check("small.dst", b_idex_dst, 1);
    check("small.rtype", b_idex_rtype, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
